// File: rtl/mmio_initiator.sv
// mmio_initiator
//   Turns single MMIO commands into one-cycle request pulses on a posted-write /
//   split-read bus. Writes complete immediately after the request pulse. Reads
//   wait for a response, or give up after TIMEOUT_CYCLES wait cycles and report
//   a timeout with all-ones data. Responses that arrive while no read is
//   outstanding, or that do not match the outstanding read, are counted.
//
// Ports
//   clk, rst              clock and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_wr/addr/wdata     command: 1 = write, 0 = read, target, write data
//   req_rd/req_wr         one-cycle request pulses
//   req_addr/wdata/tid    request payload, valid with the pulse
//   rd_valid/tid/data     responder read return
//   rsp_valid             one-cycle read completion pulse
//   rsp_data/rsp_timeout  read result, timeout flag qualifying rsp_valid
//   stray_cnt             saturating count of unmatched rd_valid pulses
//
// Build option
//   MMIO_INITIATOR_TID_CHECK_EN  when defined, a response only completes the
//                                outstanding read if rd_tid equals its tid.
module mmio_initiator #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  req_rd,
  output logic                  req_wr,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic [8:0]            req_tid,
  input  logic                  rd_valid,
  input  logic [8:0]            rd_tid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic [15:0]           stray_cnt
);

  localparam int WCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state_q, state_d;
  logic [8:0]     tid_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           accept;
  logic           match;
  logic           timeout_hit;
  logic           stray;

  // The request registers double as the captured command: req_wr tells ISSUE
  // which way to go, and req_tid holds the tid the WAIT state compares against.
`ifdef MMIO_INITIATOR_TID_CHECK_EN
  assign match = rd_valid && (rd_tid == req_tid);
`else
  logic unused_rd_tid;
  assign unused_rd_tid = ^rd_tid;
  assign match = rd_valid;
`endif

  assign cmd_ready   = (state_q == IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign timeout_hit = (wait_cnt_q == WAIT_LAST);
  assign stray       = rd_valid && !((state_q == WAIT) && match);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = req_wr ? IDLE : WAIT;
      WAIT:    if (match || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses are set on the edge that enters their cycle and cleared by default
  // on every other edge, so they are always exactly one cycle wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_rd      <= 1'b0;
      req_wr      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_tid     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      tid_q       <= '0;
      wait_cnt_q  <= '0;
      stray_cnt   <= '0;
    end else begin
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      rsp_valid <= 1'b0;

      if (accept) begin
        req_rd    <= ~cmd_wr;
        req_wr    <= cmd_wr;
        req_addr  <= cmd_addr;
        req_wdata <= cmd_wdata;
        req_tid   <= tid_q;
      end

      if (state_q == ISSUE) begin
        tid_q      <= tid_q + 9'd1;
        wait_cnt_q <= '0;
      end

      // A response arriving on the last wait cycle still wins over the timeout.
      if (state_q == WAIT) begin
        if (match) begin
          rsp_valid   <= 1'b1;
          rsp_data    <= rd_data;
          rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
          rsp_valid   <= 1'b1;
          rsp_data    <= '1;
          rsp_timeout <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
      end

      if (stray && (stray_cnt != 16'hFFFF)) stray_cnt <= stray_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mmio_initiator.sv
// Testbench for mmio_initiator with TIMEOUT_CYCLES = 8.
// The reference model works per transaction: a read whose response is offered
// d wait cycles after entering WAIT completes at wait cycle min(d, T-1), times
// out when d >= T, and rsp_valid follows one cycle later. Every rd_valid the
// bench drives that cannot complete the outstanding read adds one stray count.
module tb_mmio_initiator;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          req_rd;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [8:0]    req_tid;
  logic          rd_valid;
  logic [8:0]    rd_tid;
  logic [DW-1:0] rd_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout;
  logic [15:0]   stray_cnt;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [8:0]  model_tid;
  int unsigned stray_exp;
  logic [8:0]  last_tid;

  mmio_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tid(req_tid),
    .rd_valid(rd_valid), .rd_tid(rd_tid), .rd_data(rd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    cmd_valid = v;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic driveRd(input logic v, input logic [8:0] tid, input logic [DW-1:0] d);
    rd_valid = v;
    rd_tid   = tid;
    rd_data  = d;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    driveRd(1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    model_tid = '0;
    stray_exp = 0;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_req_rd", req_rd, 0);
    checkOutput("rst_req_wr", req_wr, 0);
    checkOutput("rst_req_addr", req_addr, 0);
    checkOutput("rst_req_wdata", req_wdata, 0);
    checkOutput("rst_req_tid", req_tid, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_timeout", rsp_timeout, 0);
    checkOutput("rst_stray_cnt", stray_cnt, 0);
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    checkOutput("wr_ready_before", cmd_ready, 1);
    applyStimulus(1'b1, 1'b1, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    last_tid = req_tid;
    checkOutput("wr_req_wr", req_wr, 1);
    checkOutput("wr_req_rd", req_rd, 0);
    checkOutput("wr_req_addr", req_addr, a);
    checkOutput("wr_req_wdata", req_wdata, d);
    checkOutput("wr_req_tid", req_tid, model_tid);
    checkOutput("wr_busy", cmd_ready, 0);
    model_tid = model_tid + 9'd1;
    tick();
    checkOutput("wr_pulse_end", req_wr, 0);
    checkOutput("wr_no_rsp", rsp_valid, 0);
    checkOutput("wr_ready_after", cmd_ready, 1);
  endtask

  // d: wait cycle at which the matching response is offered (d >= T: never).
  // wrong_k: wait cycle carrying a wrong-tid response, -1 for none.
  task automatic doRead(input logic [AW-1:0] a, input int d, input logic [DW-1:0] data,
                        input int wrong_k, input bit issue_stray);
    logic [8:0]    issued;
    int            end_k;
    bit            timed_out;
    logic [DW-1:0] exp_data;
    checkOutput("rd_ready_before", cmd_ready, 1);
    applyStimulus(1'b1, 1'b0, a, {$urandom, $urandom});
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    last_tid = req_tid;
    checkOutput("rd_req_rd", req_rd, 1);
    checkOutput("rd_req_wr", req_wr, 0);
    checkOutput("rd_req_addr", req_addr, a);
    checkOutput("rd_req_tid", req_tid, model_tid);
    issued    = model_tid;
    model_tid = model_tid + 9'd1;
    driveRd(issue_stray, issued, {$urandom, $urandom});
    if (issue_stray) stray_exp++;
    tick();
    checkOutput("rd_pulse_end", req_rd, 0);
    timed_out = (d >= T);
    end_k     = timed_out ? T - 1 : d;
    exp_data  = timed_out ? '1 : data;
    for (int k = 0; k <= end_k; k++) begin
      if (k == d) begin
        driveRd(1'b1, issued, data);
      end else if (k == wrong_k) begin
        driveRd(1'b1, issued ^ 9'h001, {$urandom, $urandom});
        stray_exp++;
      end else begin
        driveRd(1'b0, '0, '0);
      end
      tick();
      if (k < end_k) checkOutput("rd_rsp_early", rsp_valid, 0);
    end
    driveRd(1'b0, '0, '0);
    checkOutput("rd_rsp_valid", rsp_valid, 1);
    checkOutput("rd_rsp_timeout", rsp_timeout, timed_out);
    checkOutput("rd_rsp_data", rsp_data, exp_data);
    checkOutput("rd_ready_after", cmd_ready, 1);
    checkOutput("rd_stray_cnt", stray_cnt, stray_exp);
    tick();
    checkOutput("rd_rsp_once", rsp_valid, 0);
  endtask

  task automatic idleStray(input int n);
    for (int i = 0; i < n; i++) begin
      driveRd(1'($urandom_range(0, 1)), 9'($urandom), {$urandom, $urandom});
      if (rd_valid) stray_exp++;
      tick();
    end
    driveRd(1'b0, '0, '0);
    tick();
    checkOutput("idle_stray_cnt", stray_cnt, stray_exp);
    checkOutput("idle_no_rsp", rsp_valid, 0);
  endtask

  initial begin
    int d;
    int wk;
    logic [8:0] aborted;

    $display("[TB] mmio_initiator test start, TIMEOUT_CYCLES=%0d", T);
    doReset();

    // Directed cases: posted write, delayed read, minimum latency, match on
    // the timeout cycle, pure timeouts, stray response during ISSUE.
    doWrite(16'h0010, 64'hDEADBEEF);
    checkOutput("first_write_tid", last_tid, 0);
    doRead(16'h0020, 4, 64'h1234, -1, 1'b0);
    doRead(16'h0030, 0, {$urandom, $urandom}, -1, 1'b0);
    doRead(16'h0040, T - 1, {$urandom, $urandom}, -1, 1'b0);
    doRead(16'h0050, T, {$urandom, $urandom}, -1, 1'b0);
    doRead(16'h0058, T + 3, {$urandom, $urandom}, -1, 1'b0);
    doRead(16'h005C, 2, {$urandom, $urandom}, -1, 1'b1);
`ifdef MMIO_INITIATOR_TID_CHECK_EN
    doRead(16'h0060, 3, 64'hCAFE_0002, 1, 1'b0);
    doRead(16'h0064, T, {$urandom, $urandom}, T - 1, 1'b0);
`endif
    idleStray(20);

    // Randomized mix of 513 commands from reset; the 513th must reuse tid 0.
    doReset();
    for (int n = 0; n < 513; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        doWrite(16'($urandom), {$urandom, $urandom});
      end else begin
        d  = int'($urandom_range(0, T + 1));
        wk = -1;
`ifdef MMIO_INITIATOR_TID_CHECK_EN
        if (d > 0 && $urandom_range(0, 1) == 1)
          wk = int'($urandom_range(0, ((d < T) ? d : T) - 1));
`endif
        doRead(16'($urandom), d, {$urandom, $urandom}, wk, 1'($urandom_range(0, 1)));
      end
    end
    checkOutput("tid_wrap", last_tid, 0);

    // Reset in the middle of WAIT aborts the read; its late response is stray.
    doReset();
    doRead(16'h0070, T, {$urandom, $urandom}, -1, 1'b0);
    aborted = model_tid;
    applyStimulus(1'b1, 1'b0, 16'h0080, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("abort_req_rd", req_rd, 1);
    checkOutput("abort_req_tid", req_tid, aborted);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_tid = '0;
    stray_exp = 0;
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    checkOutput("abort_rsp_data", rsp_data, 0);
    checkOutput("abort_rsp_timeout", rsp_timeout, 0);
    checkOutput("abort_req_rd_clr", req_rd, 0);
    checkOutput("abort_req_tid_clr", req_tid, 0);
    checkOutput("abort_cmd_ready", cmd_ready, 1);
    driveRd(1'b1, aborted, {$urandom, $urandom});
    stray_exp++;
    tick();
    driveRd(1'b0, '0, '0);
    checkOutput("abort_late_no_rsp", rsp_valid, 0);
    tick();
    checkOutput("abort_late_stray", stray_cnt, stray_exp);
    doWrite(16'h0090, 64'h55);
    checkOutput("abort_tid_restart", last_tid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
